// File: rtl/alarm_controller.sv
// alarm_controller: keypad arm/disarm FSM with exit/entry delays, sensor watch and wrong-code lockout
module alarm_controller #(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned EXIT_DELAY     = 100_000_000,
  parameter int unsigned ENTRY_DELAY    = 50_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 150_000_000,
  parameter int unsigned MAX_TRIES      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       sensor,
  output logic       sysActive,
  output logic       armed,
  output logic [2:0] state,
  output logic [2:0] digit_cnt,
  output logic [2:0] fail_cnt
);
  typedef enum logic [2:0] {
    S_DIS   = 3'd0,
    S_EXIT  = 3'd1,
    S_ARMED = 3'd2,
    S_ENTRY = 3'd3,
    S_ALARM = 3'd4,
    S_LOCK  = 3'd5
  } state_t;
  state_t      r_state, w_nxt;
  logic [15:0] r_buf;
  logic [2:0]  r_cnt, r_fail, w_fail, w_inc;
  logic [31:0] r_timer, w_load;
  logic [1:0]  r_sync;
  logic        r_sys, r_arm;
  logic        w_lock, w_ent, w_match, w_mis, w_dig, w_reach, w_exp, w_sens;
  assign w_sens  = r_sync[1];
  assign w_lock  = r_state == S_LOCK;
  assign w_ent   = key_enter & ~key_clear & ~w_lock;
  assign w_match = w_ent & (r_cnt == 3'd4) & (r_buf == CODE);
  assign w_mis   = w_ent & ~w_match;
  assign w_dig   = key_valid & (key_digit <= 4'd9) & ~key_enter & ~key_clear & (r_cnt < 3'd4) & ~w_lock;
  assign w_inc   = (r_fail == 3'd7) ? 3'd7 : r_fail + 3'd1;
  assign w_reach = w_mis & (w_inc >= 3'(MAX_TRIES));
  assign w_exp   = r_timer == 32'd0;
  always_comb begin
    w_nxt  = r_state;
    w_fail = w_match ? 3'd0 : w_mis ? w_inc : r_fail;
    case (r_state)
      S_DIS:   w_nxt = w_match ? S_EXIT : w_reach ? S_LOCK : S_DIS;
      S_EXIT:  w_nxt = w_match ? S_DIS : w_reach ? S_LOCK : w_exp ? S_ARMED : S_EXIT;
      S_ARMED: w_nxt = w_match ? S_DIS : w_reach ? S_ALARM : w_sens ? S_ENTRY : S_ARMED;
      S_ENTRY: w_nxt = w_match ? S_DIS : (w_reach | w_exp) ? S_ALARM : S_ENTRY;
      S_ALARM: w_nxt = w_match ? S_DIS : S_ALARM;
      S_LOCK: begin
        w_nxt  = w_exp ? S_DIS : S_LOCK;
        w_fail = w_exp ? 3'd0 : r_fail;
      end
      default: w_nxt = S_DIS;
    endcase
    // load value is length-1 so the state lasts exactly the configured cycle count
    w_load = (w_nxt == S_EXIT)  ? 32'(EXIT_DELAY - 1) :
             (w_nxt == S_ENTRY) ? 32'(ENTRY_DELAY - 1) :
             (w_nxt == S_LOCK)  ? 32'(LOCKOUT_CYCLES - 1) : 32'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_DIS;
      r_buf   <= 16'd0;
      r_cnt   <= 3'd0;
      r_fail  <= 3'd0;
      r_timer <= 32'd0;
      r_sync  <= 2'd0;
      r_sys   <= 1'b0;
      r_arm   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], sensor};
      r_state <= w_nxt;
      r_fail  <= w_fail;
      r_timer <= (w_nxt != r_state) ? w_load : w_exp ? 32'd0 : r_timer - 32'd1;
      r_sys   <= w_nxt == S_ALARM;
      r_arm   <= (w_nxt == S_ARMED) | (w_nxt == S_ENTRY) | (w_nxt == S_ALARM);
      if (key_clear | w_ent | w_lock) begin
        r_buf <= 16'd0;
        r_cnt <= 3'd0;
      end else if (w_dig) begin
        r_buf <= {r_buf[11:0], key_digit};
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end
  assign state     = r_state;
  assign sysActive = r_sys;
  assign armed     = r_arm;
  assign digit_cnt = r_cnt;
  assign fail_cnt  = r_fail;
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed scenarios for alarm_controller with hand-computed expectations
module tb_alarm_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_enter = 1'b0;
  logic       key_clear = 1'b0;
  logic       sensor = 1'b0;
  logic       sysActive, armed;
  logic [2:0] state, digit_cnt, fail_cnt;
  int total = 0;
  int bad = 0;
  alarm_controller #(
    .CODE(16'h1234), .EXIT_DELAY(8), .ENTRY_DELAY(6), .LOCKOUT_CYCLES(10), .MAX_TRIES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .key_enter(key_enter), .key_clear(key_clear), .sensor(sensor),
    .sysActive(sysActive), .armed(armed), .state(state),
    .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  // all stimulus tasks start and end at a falling edge
  task automatic key(input logic [3:0] d);
    key_digit = d;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask
  task automatic enter();
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
  endtask
  task automatic code(input logic [3:0] a, b, c, d);
    key(a); key(b); key(c); key(d);
    enter();
  endtask
  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++; if (state !== s) begin bad++; $display("FAIL wait_state got=%0d exp=%0d", state, s); end
  endtask
  task automatic test_reset();
    @(negedge clk);
    total++; if ({state, digit_cnt, fail_cnt, sysActive, armed} !== 11'd0) begin bad++; $display("FAIL reset_outputs got=%b exp=0", {state, digit_cnt, fail_cnt, sysActive, armed}); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_release_state got=%0d exp=0", state); end
  endtask
  task automatic test_arm();
    int n = 0;
    code(1, 2, 3, 4);
    total++; if (state !== 3'd1 || fail_cnt !== 3'd0) begin bad++; $display("FAIL arm_enter state=%0d fail=%0d exp=1,0", state, fail_cnt); end
    while (state === 3'd1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    total++; if (n !== 8) begin bad++; $display("FAIL exit_len got=%0d exp=8", n); end
    total++; if (state !== 3'd2 || armed !== 1'b1 || sysActive !== 1'b0) begin bad++; $display("FAIL armed_outputs state=%0d armed=%b sys=%b exp=2,1,0", state, armed, sysActive); end
  endtask
  task automatic test_sensor_alarm();
    int n = 0;
    sensor = 1'b1;
    @(negedge clk); @(negedge clk);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL sensor_sync_early got=%0d exp=2", state); end
    @(negedge clk);
    total++; if (state !== 3'd3 || armed !== 1'b1) begin bad++; $display("FAIL sensor_entry state=%0d armed=%b exp=3,1", state, armed); end
    while (state === 3'd3 && n < 20) begin
      n++;
      @(negedge clk);
    end
    total++; if (n !== 6) begin bad++; $display("FAIL entry_len got=%0d exp=6", n); end
    total++; if (state !== 3'd4 || sysActive !== 1'b1 || armed !== 1'b1) begin bad++; $display("FAIL alarm_outputs state=%0d sys=%b armed=%b exp=4,1,1", state, sysActive, armed); end
    sensor = 1'b0;
    code(1, 2, 3, 4);
    total++; if (state !== 3'd0 || sysActive !== 1'b0 || armed !== 1'b0) begin bad++; $display("FAIL alarm_disarm state=%0d sys=%b armed=%b exp=0,0,0", state, sysActive, armed); end
  endtask
  task automatic test_lockout();
    int n = 0;
    code(1, 2, 3, 5);
    total++; if (fail_cnt !== 3'd1 || state !== 3'd0) begin bad++; $display("FAIL lock_try1 fail=%0d state=%0d exp=1,0", fail_cnt, state); end
    code(1, 2, 3, 5);
    total++; if (fail_cnt !== 3'd2 || state !== 3'd0) begin bad++; $display("FAIL lock_try2 fail=%0d state=%0d exp=2,0", fail_cnt, state); end
    code(1, 2, 3, 5);
    total++; if (state !== 3'd5 || fail_cnt !== 3'd3) begin bad++; $display("FAIL lock_enter state=%0d fail=%0d exp=5,3", state, fail_cnt); end
    code(1, 2, 3, 4);
    total++; if (state !== 3'd5 || digit_cnt !== 3'd0 || fail_cnt !== 3'd3) begin bad++; $display("FAIL lock_ignore state=%0d dc=%0d fail=%0d exp=5,0,3", state, digit_cnt, fail_cnt); end
    while (state === 3'd5 && n < 20) begin
      n++;
      @(negedge clk);
    end
    total++; if (n !== 5) begin bad++; $display("FAIL lock_len_remaining got=%0d exp=5", n); end
    total++; if (state !== 3'd0 || fail_cnt !== 3'd0) begin bad++; $display("FAIL lock_exit state=%0d fail=%0d exp=0,0", state, fail_cnt); end
  endtask
  task automatic test_wrong_armed();
    code(1, 2, 3, 4);
    wait_state(3'd2, 20);
    key(9); key(9); enter();
    total++; if (state !== 3'd2 || fail_cnt !== 3'd1) begin bad++; $display("FAIL armed_try1 state=%0d fail=%0d exp=2,1", state, fail_cnt); end
    key(9); key(9); enter();
    total++; if (state !== 3'd2 || fail_cnt !== 3'd2) begin bad++; $display("FAIL armed_try2 state=%0d fail=%0d exp=2,2", state, fail_cnt); end
    key(9); key(9); enter();
    total++; if (state !== 3'd4 || sysActive !== 1'b1 || fail_cnt !== 3'd3) begin bad++; $display("FAIL armed_to_alarm state=%0d sys=%b fail=%0d exp=4,1,3", state, sysActive, fail_cnt); end
    enter();
    total++; if (state !== 3'd4 || fail_cnt !== 3'd4) begin bad++; $display("FAIL alarm_mismatch state=%0d fail=%0d exp=4,4", state, fail_cnt); end
    code(1, 2, 3, 4);
    total++; if (state !== 3'd0 || fail_cnt !== 3'd0 || sysActive !== 1'b0) begin bad++; $display("FAIL alarm_match state=%0d fail=%0d sys=%b exp=0,0,0", state, fail_cnt, sysActive); end
  endtask
  task automatic test_priority();
    key(1); key(2); key(3); key(4);
    total++; if (digit_cnt !== 3'd4) begin bad++; $display("FAIL buf_count got=%0d exp=4", digit_cnt); end
    key_enter = 1'b1; key_clear = 1'b1;
    @(negedge clk);
    key_enter = 1'b0; key_clear = 1'b0;
    total++; if (state !== 3'd0 || digit_cnt !== 3'd0 || fail_cnt !== 3'd0) begin bad++; $display("FAIL clear_beats_enter state=%0d dc=%0d fail=%0d exp=0,0,0", state, digit_cnt, fail_cnt); end
    key(1); key(2); key(3); key(4); key(7);
    total++; if (digit_cnt !== 3'd4) begin bad++; $display("FAIL fifth_dropped_cnt got=%0d exp=4", digit_cnt); end
    enter();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL fifth_dropped_match got=%0d exp=1", state); end
    code(1, 2, 3, 4);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL exit_cancel got=%0d exp=0", state); end
    key(1); key(2); key(3); key(4);
    key_digit = 4'd5; key_valid = 1'b1; key_enter = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; key_enter = 1'b0;
    total++; if (state !== 3'd1 || digit_cnt !== 3'd0) begin bad++; $display("FAIL enter_beats_digit state=%0d dc=%0d exp=1,0", state, digit_cnt); end
    code(1, 2, 3, 4);
    key(1); key(10);
    total++; if (digit_cnt !== 3'd1) begin bad++; $display("FAIL non_bcd_ignored got=%0d exp=1", digit_cnt); end
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    total++; if (digit_cnt !== 3'd0 || state !== 3'd0) begin bad++; $display("FAIL clear_only dc=%0d state=%0d exp=0,0", digit_cnt, state); end
  endtask
  task automatic test_race_reset();
    code(1, 2, 3, 4);
    wait_state(3'd2, 20);
    key(1); key(2); key(3); key(4);
    sensor = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL race_entry got=%0d exp=3", state); end
    repeat (5) @(negedge clk);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL race_entry_hold got=%0d exp=3", state); end
    enter();
    total++; if (state !== 3'd0 || sysActive !== 1'b0) begin bad++; $display("FAIL match_beats_expiry state=%0d sys=%b exp=0,0", state, sysActive); end
    sensor = 1'b0;
    code(1, 2, 3, 4);
    wait_state(3'd2, 20);
    sensor = 1'b1;
    wait_state(3'd4, 20);
    sensor = 1'b0;
    enter();
    #2 rst_n = 1'b0;
    #1;
    total++; if ({state, digit_cnt, fail_cnt, sysActive, armed} !== 11'd0) begin bad++; $display("FAIL async_reset got=%b exp=0", {state, digit_cnt, fail_cnt, sysActive, armed}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (state !== 3'd0 || fail_cnt !== 3'd0) begin bad++; $display("FAIL post_reset state=%0d fail=%0d exp=0,0", state, fail_cnt); end
  endtask
  initial begin
    test_reset();
    test_arm();
    test_sensor_alarm();
    test_lockout();
    test_wrong_armed();
    test_priority();
    test_race_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alarm_controller.md
# alarm_controller

Keypad-driven arm/disarm state machine for the security system. It collects a 4-digit BCD code, runs the exit and entry delays, watches the door/motion sensor, and counts failed code attempts. Its `sysActive` output drives the downstream beep/blink stage: the speaker and LED alarm runs exactly while `sysActive` is high.

## Interface
- `CODE`, 16'h1234: disarm/arm code, 4 BCD digits, most significant digit entered first
- `EXIT_DELAY`, 100_000_000: cycles spent in EXIT before reaching ARMED
- `ENTRY_DELAY`, 50_000_000: cycles spent in ENTRY before reaching ALARM
- `LOCKOUT_CYCLES`, 150_000_000: cycles spent in LOCKOUT
- `MAX_TRIES`, 3: consecutive wrong codes that trigger the penalty, range 1..7
- `clk`  in  1  system clock; one clock domain
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `key_valid`  in  1  one-cycle strobe; `key_digit` is valid in that cycle
- `key_digit`  in  4  BCD digit; values above 9 are ignored
- `key_enter`  in  1  one-cycle strobe; evaluate the buffered code
- `key_clear`  in  1  one-cycle strobe; discard the buffered digits
- `sensor`  in  1  asynchronous door/motion input, active-high
- `sysActive`  out  1  alarm sounding; high only in ALARM
- `armed`  out  1  high in ARMED, ENTRY and ALARM
- `state`  out  3  DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4, LOCKOUT=5
- `digit_cnt`  out  3  number of buffered digits, 0..4
- `fail_cnt`  out  3  consecutive wrong-code count

## Operation
- **Digit buffer**
  - A valid digit (`key_valid`=1 and `key_digit`≤9) shifts into a 16-bit buffer when `digit_cnt`<4; `digit_cnt` then increments.
  - A 5th or later digit is dropped.
- **Code evaluation on `key_enter`**
  - match = (`digit_cnt`==4 and buffer==`CODE`). Anything else is a mismatch.
  - The buffer and `digit_cnt` clear on every enter, match or not.
- **Same-cycle priority of keypad strobes**
  - `key_clear` beats `key_enter`: the buffer clears, nothing is evaluated, and `fail_cnt` is unchanged.
  - `key_enter` beats `key_valid`: the code is evaluated without the new digit, and that digit is dropped.
- **Sensor path**
  - `sensor` passes through a 2-flop synchronizer; `sens_s` is the synchronized version.
  - `sens_s` is the only version of the sensor the FSM uses.
- **Timer**
  - One 32-bit down-counter shared by EXIT, ENTRY and LOCKOUT.
  - Loaded on entry to each of those states; timer expiry is the transition event.
- **State transitions**
  - DISARMED:
    - match → EXIT, `fail_cnt`←0.
    - mismatch → `fail_cnt`+1; on reaching `MAX_TRIES` → LOCKOUT.
  - EXIT:
    - match → DISARMED (cancel).
    - expiry → ARMED.
    - `sens_s` is ignored.
    - mismatch is handled as in DISARMED (can go to LOCKOUT).
  - ARMED:
    - match → DISARMED.
    - `sens_s`=1 → ENTRY.
    - mismatch → `fail_cnt`+1; on reaching `MAX_TRIES` → ALARM.
  - ENTRY:
    - match → DISARMED.
    - expiry → ALARM.
    - mismatch is handled as in ARMED.
  - ALARM:
    - match → DISARMED.
    - mismatch → `fail_cnt` saturates at 7; the state is unchanged.
  - LOCKOUT:
    - All keypad strobes are ignored and the buffer is held clear.
    - expiry → DISARMED, `fail_cnt`←0.
- **Match side effects**
  - Every match clears `fail_cnt`.
  - A match in ARMED, ENTRY or ALARM returns the block to DISARMED, and `sysActive` drops.
- **Simultaneous events**
  - A match beats timer expiry.
  - A match beats `sens_s` in the same cycle.
  - Reaching `MAX_TRIES` beats timer expiry.

## Timing
- **Reset:** `rst_n`=0 asynchronously forces:
  - `state`=DISARMED
  - `sysActive`=0, `armed`=0
  - `digit_cnt`=0, `fail_cnt`=0
  - timer and synchronizer = 0
- **Reset release:** the first active edge after `rst_n` rises behaves as normal operation.
- **Reset mid-operation:** reset during any state, including ALARM, returns to DISARMED with no residual count.
- **Registered outputs:** all outputs are registered and derived from `state` and the counters.
- **Latency**
  - Enter strobe at edge N → new `state` and `fail_cnt` visible after edge N.
  - `sensor` rising → ENTRY visible 3 edges later (2 synchronizer edges + 1 FSM edge).
- **Delay lengths:** `state` holds EXIT for exactly `EXIT_DELAY` cycles, ENTRY for exactly `ENTRY_DELAY` cycles, and LOCKOUT for exactly `LOCKOUT_CYCLES` cycles. The count starts at the edge where the state is entered.
- **Strobe width:** strobes are treated as one-cycle pulses; a strobe held high is evaluated again every cycle.

## Test plan
Parameters for all scenarios: `CODE`=16'h1234, `EXIT_DELAY`=8, `ENTRY_DELAY`=6, `LOCKOUT_CYCLES`=10, `MAX_TRIES`=3.

1. **Arm and exit delay:** digits 1,2,3,4 + enter → `state`=1 for exactly 8 cycles, then `state`=2 with `armed`=1 and `sysActive`=0.
2. **Sensor to alarm:** from ARMED, raise `sensor` → `state`=3 three edges later; after 6 more cycles `state`=4 and `sysActive`=1. Then enter 1,2,3,4 + enter → `state`=0 and `sysActive`=0 on the next edge.
3. **Lockout:** in DISARMED, enter 1,2,3,5 + enter three times → `fail_cnt` goes 1, 2, then `state`=5. During 10 lockout cycles, entering 1,2,3,4 + enter has no effect. Then `state`=0 and `fail_cnt`=0.
4. **Wrong codes while armed:** in ARMED, enter 9,9 + enter three times → `state`=4 and `sysActive`=1.
5. **Strobe priority:**
   - `key_enter` with `key_clear` after 1,2,3,4 → no transition, `digit_cnt`=0, `fail_cnt`=0.
   - Digits 1,2,3,4,7 + enter → match (5th digit dropped).
   - Digit 10 ignored, `digit_cnt` unchanged.
6. **Timer/match race and reset:**
   - A match arriving on the cycle ENTRY expires → `state`=0, not 4.
   - `rst_n` pulsed low in ALARM → `state`=0 and all outputs 0 immediately, without waiting for a clock edge.
